// File: rtl/seq_control.sv
// seq_control: multi-cycle instruction sequencer. It steps through fetch, decode,
// execute, optional memory access and writeback, issues the memory requests,
// produces the ALU load and writeback strobes, and traps into a sticky fault
// state when a memory access waits too long.

package seq_control_pkg;

    // Decoded instruction type codes shared with the decoder.
    typedef enum logic [4:0] {
        IT_HOLD  = 5'd0,
        IT_RTYPE = 5'd1,
        IT_ITYPE = 5'd2,
        IT_STYPE = 5'd3,
        IT_UTYPE = 5'd4,
        IT_LTYPE = 5'd5
    } itype_e;

    // Sequencer states; the value is also the externally visible stage code.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_FAULT  = 3'd7
    } state_e;

endpackage

module seq_control
    import seq_control_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int TIMEOUT  = 15,
    parameter bit SKIP_MEM = 1'b1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    output logic [2:0]       stage_o,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [XLEN-1:0]  mem_addr_o,
    input  logic             mem_ready_i,
    input  logic [XLEN-1:0]  mem_rdata_i,
    input  logic [XLEN-1:0]  pc_i,
    input  logic [XLEN-1:0]  daddr_i,
    output logic             pc_advance_o,
    output logic [XLEN-1:0]  ir_o,
    input  logic [4:0]       itype_i,
    output logic             readin_a_o,
    output logic             readin_b_o,
    output logic             readin_pass_o,
    output logic             wd_q_readin_o,
    output logic             wd_q_o,
    input  logic             stall_i,
    output logic             fault_o,
    output logic [CNT_W-1:0] retire_cnt_o
);

    localparam bit             HAS_TIMEOUT = (TIMEOUT > 0);
    localparam int             WAIT_W      = HAS_TIMEOUT ? $clog2(TIMEOUT + 1) : 1;
    // Counter value seen in the last waiting cycle before the fault fires.
    localparam logic [WAIT_W-1:0] WAIT_LAST = HAS_TIMEOUT ? WAIT_W'(TIMEOUT - 1) : '0;

    state_e            r_state;
    state_e            w_state_next;
    itype_e            r_itype_q;
    logic [XLEN-1:0]   r_ir;
    logic [WAIT_W-1:0] r_wait;
    logic [CNT_W-1:0]  r_retire;
    logic              r_wdq_pulse;

    logic w_itype_legal;
    logic w_is_mem_type;
    logic w_waiting;
    logic w_timeout;
    logic w_wdq_set;
    logic w_retire;
    logic w_exec_skip;

    // Unknown type codes collapse to HOLD when they are latched in DECODE.
    assign w_itype_legal = itype_i inside {IT_HOLD, IT_RTYPE, IT_ITYPE,
                                           IT_STYPE, IT_UTYPE, IT_LTYPE};
    assign w_is_mem_type = (r_itype_q == IT_STYPE) || (r_itype_q == IT_LTYPE);
    // Only FETCH and a real load/store in MEM wait on the memory.
    assign w_waiting     = (r_state == S_FETCH) || ((r_state == S_MEM) && w_is_mem_type);
    // A ready in the final allowed cycle is honoured because it is tested first.
    assign w_timeout     = HAS_TIMEOUT && w_waiting && !mem_ready_i && (r_wait == WAIT_LAST);
    assign w_exec_skip   = SKIP_MEM && !w_is_mem_type && (r_itype_q != IT_HOLD);

    assign stage_o      = r_state;
    assign ir_o         = r_ir;
    assign fault_o      = (r_state == S_FAULT);
    assign retire_cnt_o = r_retire;

    // State register.
    // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state selection plus the one-cycle events that depend on the transition.
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_wdq_set    = 1'b0;
        w_retire     = 1'b0;
        case (r_state)
            S_IDLE:   w_state_next = S_FETCH;
            S_FETCH: begin
                if (mem_ready_i)    w_state_next = S_DECODE;
                else if (w_timeout) w_state_next = S_FAULT;
            end
            S_DECODE: w_state_next = S_EXEC;
            S_EXEC: begin
                case (r_itype_q)
                    IT_STYPE, IT_LTYPE: w_state_next = S_MEM;
                    IT_HOLD:            w_state_next = S_WB;
                    default:            w_state_next = SKIP_MEM ? S_WB : S_MEM;
                endcase
            end
            S_MEM: begin
                if (!w_is_mem_type || mem_ready_i) begin
                    w_state_next = S_WB;
                    w_wdq_set    = 1'b1;
                end else if (w_timeout) begin
                    w_state_next = S_FAULT;
                end
            end
            S_WB: begin
                if (!stall_i) begin
                    w_state_next = S_FETCH;
                    w_retire     = 1'b1;
                end
            end
            S_FAULT:  w_state_next = S_FAULT;
            default:  w_state_next = S_FETCH;  // unused code 6 behaves like IDLE
        endcase
    end

    // Memory request and strobe decode from the registered state and itype_q.
    always_comb begin
        mem_req_o     = 1'b0;
        mem_we_o      = 1'b0;
        mem_addr_o    = '0;
        readin_a_o    = 1'b0;
        readin_b_o    = 1'b0;
        readin_pass_o = 1'b0;
        wd_q_readin_o = r_wdq_pulse;
        wd_q_o        = 1'b0;
        pc_advance_o  = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_req_o  = 1'b1;
                mem_addr_o = pc_i;
            end
            S_EXEC: begin
                wd_q_readin_o = w_exec_skip;
                case (r_itype_q)
                    IT_RTYPE, IT_ITYPE, IT_LTYPE: begin
                        readin_a_o = 1'b1;
                        readin_b_o = 1'b1;
                    end
                    IT_STYPE: begin
                        readin_a_o    = 1'b1;
                        readin_b_o    = 1'b1;
                        readin_pass_o = 1'b1;
                    end
                    IT_UTYPE: readin_pass_o = 1'b1;
                    default: ;
                endcase
            end
            S_MEM: begin
                if (w_is_mem_type) begin
                    mem_req_o  = 1'b1;
                    mem_we_o   = (r_itype_q == IT_STYPE);
                    mem_addr_o = daddr_i;
                end
            end
            S_WB: begin
                if (!stall_i) begin
                    pc_advance_o = 1'b1;
                    wd_q_o       = (r_itype_q != IT_STYPE) && (r_itype_q != IT_HOLD);
                end
            end
            default: ;
        endcase
    end

    // Instruction/type capture, memory wait counter, retire counter and the
    // registered writeback-capture pulse.
    // NOTE: every register here is cleared by reset; there is no storage array to exempt.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ir        <= '0;
            r_itype_q   <= IT_HOLD;
            r_wait      <= '0;
            r_retire    <= '0;
            r_wdq_pulse <= 1'b0;
        end else begin
            r_wdq_pulse <= w_wdq_set;
            if ((r_state == S_FETCH) && mem_ready_i) begin
                r_ir <= mem_rdata_i;
            end
            if (r_state == S_DECODE) begin
                r_itype_q <= w_itype_legal ? itype_e'(itype_i) : IT_HOLD;
            end
            if (w_waiting && !mem_ready_i) begin
                r_wait <= r_wait + 1'b1;
            end else begin
                r_wait <= '0;
            end
            if (w_retire) begin
                r_retire <= r_retire + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seq_control.sv
// tb_seq_control: randomized instruction stream checked cycle by cycle against a
// trace model built from per-instruction wait/stall counts, plus literal checks
// of the stage sequences, timeout, counter wrap and asynchronous reset behaviour.
`timescale 1ns/1ps

module tb_seq_control;
    import seq_control_pkg::*;

    localparam int XLEN    = 32;
    localparam int TIMEOUT = 15;
    localparam int CNT_W   = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic [2:0]       stage_o;
    logic             mem_req_o, mem_we_o;
    logic [XLEN-1:0]  mem_addr_o;
    logic             mem_ready_i;
    logic [XLEN-1:0]  mem_rdata_i, pc_i, daddr_i;
    logic             pc_advance_o;
    logic [XLEN-1:0]  ir_o;
    logic [4:0]       itype_i;
    logic             readin_a_o, readin_b_o, readin_pass_o;
    logic             wd_q_readin_o, wd_q_o;
    logic             stall_i;
    logic             fault_o;
    logic [CNT_W-1:0] retire_cnt_o;

    seq_control #(.XLEN(XLEN), .TIMEOUT(TIMEOUT), .SKIP_MEM(1'b1), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .stage_o(stage_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i),
        .pc_i(pc_i), .daddr_i(daddr_i), .pc_advance_o(pc_advance_o), .ir_o(ir_o),
        .itype_i(itype_i), .readin_a_o(readin_a_o), .readin_b_o(readin_b_o),
        .readin_pass_o(readin_pass_o), .wd_q_readin_o(wd_q_readin_o), .wd_q_o(wd_q_o),
        .stall_i(stall_i), .fault_o(fault_o), .retire_cnt_o(retire_cnt_o)
    );

    always #5 clk = ~clk;

    // One clock cycle of the expected trace: stimulus to drive and outputs to see.
    typedef struct {
        logic             ready, stall;
        logic [31:0]      rdata, pc, daddr;
        logic [4:0]       itype;
        logic [2:0]       stage;
        logic             req, we;
        logic [31:0]      addr;
        logic             pcadv;
        logic [31:0]      ir;
        logic             a, b, pass, wdr, wdq, fault;
        logic [CNT_W-1:0] retire;
    } cyc_t;

    cyc_t q[$];
    cyc_t exp_c;
    bit   chk_en;
    int   n_checks, n_errors;

    logic [31:0] m_ir;
    int          m_retire;

    logic [2:0]       stage_log[$];
    logic             we_log[$], pass_log[$], wdq_log[$], pcadv_log[$], fault_log[$];
    logic [31:0]      addr_log[$];
    logic [CNT_W-1:0] retire_log[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // A cycle with random junk on every input and all strobes expected low.
    function automatic cyc_t base(input logic [2:0] stage);
        cyc_t c;
        c.ready  = 1'($urandom);
        c.stall  = 1'($urandom);
        c.rdata  = $urandom;
        c.pc     = $urandom;
        c.daddr  = $urandom;
        c.itype  = 5'($urandom);
        c.stage  = stage;
        c.req    = 1'b0;
        c.we     = 1'b0;
        c.addr   = 32'd0;
        c.pcadv  = 1'b0;
        c.ir     = m_ir;
        c.a      = 1'b0;
        c.b      = 1'b0;
        c.pass   = 1'b0;
        c.wdr    = 1'b0;
        c.wdq    = 1'b0;
        c.fault  = (stage == 3'd7);
        c.retire = CNT_W'(m_retire);
        return c;
    endfunction

    // Append one instruction: nf/nm wait cycles before ready, ns stalled WB cycles.
    task automatic add_instr(input logic [4:0] raw, input int nf, input int nm, input int ns,
                             input bit fix_da, input logic [31:0] da, input bit abort_mem);
        cyc_t        c;
        logic [4:0]  eff;
        bit          memt, st;
        logic [31:0] new_ir;
        eff  = (raw inside {IT_HOLD, IT_RTYPE, IT_ITYPE, IT_STYPE, IT_UTYPE, IT_LTYPE})
               ? raw : IT_HOLD;
        st   = (eff == IT_STYPE);
        memt = st || (eff == IT_LTYPE);
        new_ir = m_ir;
        for (int k = 0; k <= nf; k++) begin
            c = base(3'd1);
            c.ready = (k == nf);
            c.req   = 1'b1;
            c.addr  = c.pc;
            if (k == nf) new_ir = c.rdata;
            q.push_back(c);
        end
        m_ir = new_ir;
        c = base(3'd2);
        c.itype = raw;
        q.push_back(c);
        c = base(3'd3);
        c.a    = eff inside {IT_RTYPE, IT_ITYPE, IT_LTYPE, IT_STYPE};
        c.b    = c.a;
        c.pass = eff inside {IT_STYPE, IT_UTYPE};
        c.wdr  = !memt && (eff != IT_HOLD);
        q.push_back(c);
        if (memt) begin
            for (int k = 0; k <= nm; k++) begin
                c = base(3'd4);
                c.ready = abort_mem ? 1'b0 : (k == nm);
                c.req   = 1'b1;
                c.we    = st;
                if (fix_da) c.daddr = da;
                c.addr  = c.daddr;
                q.push_back(c);
            end
            if (abort_mem) return;
        end
        for (int k = 0; k <= ns; k++) begin
            c = base(3'd5);
            c.stall = (k < ns);
            c.wdr   = memt && (k == 0);
            c.wdq   = (k == ns) && (eff inside {IT_RTYPE, IT_ITYPE, IT_UTYPE, IT_LTYPE});
            c.pcadv = (k == ns);
            q.push_back(c);
        end
        m_retire++;
    endtask

    function automatic logic [4:0] pick_itype();
        logic [4:0] tab [6];
        tab[0] = IT_HOLD;  tab[1] = IT_RTYPE; tab[2] = IT_ITYPE;
        tab[3] = IT_STYPE; tab[4] = IT_UTYPE; tab[5] = IT_LTYPE;
        if ($urandom_range(0, 9) < 8) return tab[$urandom_range(0, 5)];
        return 5'($urandom);
    endfunction

    // Play the queued trace, one entry per clock, starting in the current cycle.
    task automatic run_queue();
        cyc_t c;
        while (q.size() > 0) begin
            c = q.pop_front();
            mem_ready_i = c.ready;
            stall_i     = c.stall;
            mem_rdata_i = c.rdata;
            pc_i        = c.pc;
            daddr_i     = c.daddr;
            itype_i     = c.itype;
            exp_c       = c;
            chk_en      = 1'b1;
            @(negedge clk);
            #1;
            @(posedge clk);
            #1;
        end
        chk_en = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stage"}, stage_o, 0);
        check({tag, "_req"}, mem_req_o, 0);
        check({tag, "_we"}, mem_we_o, 0);
        check({tag, "_addr"}, mem_addr_o, 0);
        check({tag, "_pcadv"}, pc_advance_o, 0);
        check({tag, "_ir"}, ir_o, 0);
        check({tag, "_strobes"}, {readin_a_o, readin_b_o, readin_pass_o, wd_q_readin_o, wd_q_o}, 0);
        check({tag, "_fault"}, fault_o, 0);
        check({tag, "_retire"}, retire_cnt_o, 0);
    endtask

    // Compare every output with the model trace on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("stage", stage_o, exp_c.stage);
            check("mem_req", mem_req_o, exp_c.req);
            check("mem_we", mem_we_o, exp_c.we);
            check("mem_addr", mem_addr_o, exp_c.addr);
            check("pc_advance", pc_advance_o, exp_c.pcadv);
            check("ir", ir_o, exp_c.ir);
            check("readin_a", readin_a_o, exp_c.a);
            check("readin_b", readin_b_o, exp_c.b);
            check("readin_pass", readin_pass_o, exp_c.pass);
            check("wd_q_readin", wd_q_readin_o, exp_c.wdr);
            check("wd_q", wd_q_o, exp_c.wdq);
            check("fault", fault_o, exp_c.fault);
            check("retire_cnt", retire_cnt_o, exp_c.retire);
            stage_log.push_back(stage_o);
            we_log.push_back(mem_we_o);
            addr_log.push_back(mem_addr_o);
            pass_log.push_back(readin_pass_o);
            wdq_log.push_back(wd_q_o);
            pcadv_log.push_back(pc_advance_o);
            fault_log.push_back(fault_o);
            retire_log.push_back(retire_cnt_o);
        end
    end

    initial begin
        int mk_s, mk_st, mk_5, mk_to, cnt, cnt2;
        logic [4:0] rt;
        n_checks = 0; n_errors = 0; chk_en = 1'b0;
        m_ir = '0; m_retire = 0;
        reset = 1'b1;
        mem_ready_i = 1'b0; stall_i = 1'b0; mem_rdata_i = '0;
        pc_i = 32'h40; daddr_i = '0; itype_i = '0;
        #1;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Directed opening followed by a random stream and a fetch timeout.
        q.push_back(base(3'd0));
        add_instr(IT_RTYPE, 0, 0, 0, 1'b0, 32'd0, 1'b0);
        mk_s = q.size();
        add_instr(IT_STYPE, 0, 3, 0, 1'b1, 32'h100, 1'b0);
        mk_st = q.size();
        add_instr(IT_RTYPE, 1, 0, 2, 1'b0, 32'd0, 1'b0);
        add_instr(IT_ITYPE, 2, 0, 1, 1'b0, 32'd0, 1'b0);
        add_instr(IT_LTYPE, 1, 2, 1, 1'b0, 32'd0, 1'b0);
        mk_5 = q.size();
        for (int i = 0; i < 40; i++) begin
            add_instr(pick_itype(), $urandom_range(0, 4), $urandom_range(0, 4),
                      $urandom_range(0, 2), 1'b0, 32'd0, 1'b0);
        end
        mk_to = q.size();
        for (int k = 0; k < TIMEOUT; k++) begin
            cyc_t c;
            c = base(3'd1);
            c.ready = 1'b0;
            c.req   = 1'b1;
            c.addr  = c.pc;
            q.push_back(c);
        end
        for (int k = 0; k < 5; k++) q.push_back(base(3'd7));
        run_queue();

        // Literal expectations on the recorded DUT trace.
        check("rtype_seq0", stage_log[0], 0);
        check("rtype_seq1", stage_log[1], 1);
        check("rtype_seq2", stage_log[2], 2);
        check("rtype_seq3", stage_log[3], 3);
        check("rtype_seq4", stage_log[4], 5);
        check("rtype_seq5", stage_log[5], 1);
        cnt = 0; cnt2 = 0;
        for (int i = 1; i <= 4; i++) begin
            cnt  += int'(wdq_log[i]);
            cnt2 += int'(pcadv_log[i]);
        end
        check("rtype_wdq_cycles", cnt, 1);
        check("rtype_pcadv_cycles", cnt2, 1);
        check("rtype_retire_before", retire_log[4], 0);
        check("rtype_retire_after", retire_log[5], 1);
        cnt = 0; cnt2 = 0;
        for (int i = mk_s; i < mk_st; i++) begin
            if (we_log[i] && addr_log[i] == 32'h100) cnt++;
            cnt2 += int'(wdq_log[i]);
        end
        check("store_we_cycles", cnt, 4);
        check("store_wdq_cycles", cnt2, 0);
        check("store_pass_exec", pass_log[mk_s + 2], 1);
        check("stall_wb0", stage_log[mk_st + 4], 5);
        check("stall_wb2", stage_log[mk_st + 6], 5);
        check("stall_next", stage_log[mk_st + 7], 1);
        check("stall_pcadv", {pcadv_log[mk_st + 4], pcadv_log[mk_st + 5], pcadv_log[mk_st + 6]}, 3'b001);
        check("retire_wrap", retire_log[mk_5], 1);
        check("timeout_last_fetch", stage_log[mk_to + TIMEOUT - 1], 1);
        check("timeout_stage", stage_log[mk_to + TIMEOUT], 7);
        check("timeout_fault", fault_log[mk_to + TIMEOUT], 1);
        check("fault_held", stage_log[mk_to + TIMEOUT + 4], 7);

        // Asynchronous reset: out of FAULT, then in the middle of a load and a store wait.
        for (int t = 0; t < 2; t++) begin
            rt = (t == 0) ? IT_LTYPE : IT_STYPE;
            reset = 1'b1;
            #1 check_all_zero("reset_async");
            m_ir = '0; m_retire = 0;
            q.push_back(base(3'd0));
            add_instr(rt, 0, 3, 0, 1'b0, 32'd0, 1'b1);
            repeat (2) @(posedge clk);
            #1 reset = 1'b0;
            run_queue();
            check("mid_mem_req", mem_req_o, 1);
            check("mid_mem_we", mem_we_o, (t == 1));
            #2 reset = 1'b1;
            #1 check_all_zero("reset_mid_mem");
            m_ir = '0; m_retire = 0;
            q.push_back(base(3'd0));
            add_instr(rt, 1, 0, 0, 1'b0, 32'd0, 1'b0);
            repeat (2) @(posedge clk);
            #1 reset = 1'b0;
            run_queue();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_control.md
SEQ_CONTROL -- requirements
Module: seq_control

Interface
REQ-001 Parameters: XLEN (default 32), datapath/address width; TIMEOUT (default 15), memory wait limit in cycles, 0 = no limit; SKIP_MEM (default 1), 1 = non-memory types bypass MEM stage; CNT_W (default 16), retire counter width.
REQ-002 Ports, clock and reset first:
 clk  in  1  sole clock, rising edge.
 reset  in  1  asynchronous, active-high.
 stage_o  out  3  current state code.
 mem_req_o  out  1  memory request.
 mem_we_o  out  1  write request, valid only with mem_req_o.
 mem_addr_o  out  XLEN  request address.
 mem_ready_i  in  1  request completes this cycle.
 mem_rdata_i  in  XLEN  read data, valid with mem_ready_i.
 pc_i  in  XLEN  current PC.
 daddr_i  in  XLEN  data address from ALU.
 pc_advance_o  out  1  one-cycle PC update pulse.
 ir_o  out  XLEN  instruction register.
 itype_i  in  5  decoded type (shared itype codes).
 readin_a_o / readin_b_o / readin_pass_o  out  1 each  ALU operand/pass load strobes.
 wd_q_readin_o  out  1  writeback-data capture strobe.
 wd_q_o  out  1  register-file write enable.
 stall_i  in  1  hold writeback/PC advance.
 fault_o  out  1  sticky memory-timeout fault.
 retire_cnt_o  out  CNT_W  retired instruction count.

Function
REQ-003 States/stage_o codes: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, FAULT=7; code 6 unused, treated as IDLE.
REQ-004 IDLE -> FETCH on the first clock edge after reset deasserts.
REQ-005 FETCH: mem_req_o=1, mem_we_o=0, mem_addr_o=pc_i; on the mem_ready_i=1 edge, ir <= mem_rdata_i and state -> DECODE; otherwise stay.
REQ-006 DECODE: itype_i is registered into itype_q; duration 1 cycle; -> EXEC.
REQ-007 Any itype value outside RTYPE/ITYPE/STYPE/UTYPE/LTYPE/HOLD is treated as HOLD.
REQ-008 EXEC lasts 1 cycle; strobes (a,b,pass) are asserted only in EXEC, by itype_q: RTYPE/ITYPE/LTYPE 1,1,0; STYPE 1,1,1; UTYPE 0,0,1; HOLD 0,0,0.
REQ-009 EXEC exit: STYPE/LTYPE -> MEM; HOLD -> WB; other types -> WB if SKIP_MEM=1, else -> MEM.
REQ-010 MEM for STYPE: mem_req_o=1, mem_we_o=1, mem_addr_o=daddr_i until mem_ready_i; LTYPE: same with mem_we_o=0; other types: no request, 1 cycle.
REQ-011 wd_q_readin_o pulses 1 cycle on MEM exit (ready edge) for all types except HOLD; when MEM is skipped, it pulses in the EXEC cycle instead.
REQ-012 WB: when stall_i=0, wd_q_o=1 for RTYPE/ITYPE/UTYPE/LTYPE only, pc_advance_o=1, retire_cnt_o increments (wraps at 2^CNT_W), and state -> FETCH. When stall_i=1, the FSM stays in WB with wd_q_o=0 and pc_advance_o=0.
REQ-013 Wait counter: cleared on entry to FETCH/MEM; increments each cycle without mem_ready_i. When it reaches TIMEOUT (TIMEOUT>0), state -> FAULT. mem_ready_i arriving in the same cycle wins over timeout.
REQ-014 FAULT: fault_o=1 and all strobes and requests are 0; FAULT is left only by reset.
REQ-015 Outside FETCH/MEM, mem_req_o=0 and mem_we_o=0; mem_addr_o=0 when mem_req_o=0.
REQ-016 All strobes are glitch-free: decoded from registered state/itype_q only, never from mem_ready_i combinationally except as permitted in REQ-011 (registered pulse).

Reset
REQ-017 Assertion of reset immediately (asynchronously) forces: state IDLE, stage_o=0, ir_o=0, itype_q=0, wait counter 0, retire_cnt_o=0, fault_o=0, and every strobe/request output 0.
REQ-018 Reset mid-MEM store drops mem_req_o/mem_we_o in the same cycle; no partial write is re-issued after release.

Verification
REQ-019 RTYPE, zero-wait memory, SKIP_MEM=1 -> stage sequence 1,2,3,5,1; wd_q_o and pc_advance_o high exactly 1 cycle; retire_cnt_o 0->1.
REQ-020 STYPE with mem_ready_i delayed 3 cycles, daddr_i=0x100 -> mem_we_o=1 at addr 0x100 for 4 cycles, readin_pass_o=1 in EXEC, wd_q_o never asserted.
REQ-021 FETCH with mem_ready_i never asserted, TIMEOUT=15 -> stage_o=7 and fault_o=1 after 15 wait cycles; state held until reset.
REQ-022 stall_i=1 for 2 cycles in WB -> WB lasts 3 cycles; pc_advance_o pulses once, on the last cycle.
REQ-023 retire_cnt_o with CNT_W=2 after 5 retirements -> value 1 (wrap).
REQ-024 Reset asserted during LTYPE MEM wait -> all outputs 0 in the same cycle; after release, FETCH at pc_i.
